// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, grant/response and memory-side signals of mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_i_req;
  logic [ADDR_W-1:0] i_i_addr;
  logic              o_i_gnt;
  logic              o_i_rvalid;
  logic [DATA_W-1:0] o_i_rdata;
  logic              i_d_req;
  logic [ADDR_W-1:0] i_d_addr;
  logic              i_d_wren;
  logic [DATA_W-1:0] i_d_wdata;
  logic [DATA_W/8-1:0] i_d_bmask;
  logic              i_d_lock;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W/8-1:0] o_mem_bmask;
  logic              o_mem_wren;
  logic [DATA_W-1:0] i_mem_rdata;
  modport slave (
    input  i_i_req, i_i_addr, i_d_req, i_d_addr, i_d_wren, i_d_wdata, i_d_bmask, i_d_lock, i_mem_rdata,
    output o_i_gnt, o_i_rvalid, o_i_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
           o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );
  modport master (
    output i_i_req, i_i_addr, i_d_req, i_d_addr, i_d_wren, i_d_wdata, i_d_bmask, i_d_lock, i_mem_rdata,
    input  o_i_gnt, o_i_rvalid, o_i_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
           o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D arbiter for one shared memory, with D-side lock and registered read data.
// ARB_FIXED_PRIO_EN: when defined, idle contention always goes to D.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] o_conflict_cnt
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state, w_state_nx;
  logic r_last_d, w_last_d_nx, w_i_win, w_d_win, w_deny;
  logic r_i_rvalid, r_d_rvalid;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    w_i_win = 1'b0;
    w_d_win = 1'b0;
    w_state_nx = r_state;
    w_last_d_nx = r_last_d;
    if (i_reset_n) begin
      if (r_state == LOCKED) w_d_win = bus.i_d_req;
      else if (bus.i_i_req && bus.i_d_req) begin
`ifdef ARB_FIXED_PRIO_EN
        w_d_win = 1'b1;
`else
        w_d_win = !r_last_d;
`endif
        w_i_win = !w_d_win;
      end else begin
        w_i_win = bus.i_i_req;
        w_d_win = bus.i_d_req;
      end
    end
    if (w_d_win) w_state_nx = bus.i_d_lock ? LOCKED : IDLE;
`ifndef ARB_FIXED_PRIO_EN
    if (r_state == IDLE && (w_i_win || w_d_win)) w_last_d_nx = w_d_win;
`endif
  end
  assign w_deny          = (bus.i_i_req && !w_i_win) || (bus.i_d_req && !w_d_win);
  assign bus.o_i_gnt     = w_i_win;
  assign bus.o_d_gnt     = w_d_win;
  assign bus.o_mem_addr  = w_d_win ? bus.i_d_addr : bus.i_i_addr;
  assign bus.o_mem_wdata = w_d_win ? bus.i_d_wdata : '0;
  assign bus.o_mem_bmask = w_d_win ? bus.i_d_bmask : '0;
  assign bus.o_mem_wren  = w_d_win && bus.i_d_wren;
  assign bus.o_i_rvalid  = r_i_rvalid;
  assign bus.o_i_rdata   = r_i_rdata;
  assign bus.o_d_rvalid  = r_d_rvalid;
  assign bus.o_d_rdata   = r_d_rdata;
  assign o_conflict_cnt  = r_cnt;
  // read data is captured on the same edge that commits a write, so D sees the pre-write word
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_last_d   <= w_last_d_nx;
      r_i_rvalid <= w_i_win;
      r_d_rvalid <= w_d_win;
      if (w_i_win) r_i_rdata <= bus.i_mem_rdata;
      if (w_d_win) r_d_rdata <= bus.i_mem_rdata;
      if (w_deny && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a behavioural model.
module tb_mem_arbiter;
  localparam int CW = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] cnt;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int checks = 0;
  int errors = 0;
  bit m_locked, m_last_d, e_iv, e_dv, obs_i, obs_d;
  logic [31:0] e_ird, e_drd;
  int m_cnt;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .o_conflict_cnt(cnt)
  );
  always #5 clk = ~clk;
  assign bus.i_mem_rdata = mem[bus.o_mem_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                     input bit dw, input logic [31:0] wd, input logic [3:0] bm, input bit lk);
    bit ei, ed, wr;
    logic [31:0] wa, wv;
    logic [3:0] wb;
    @(negedge clk);
    bus.i_i_req = ir; bus.i_i_addr = ia; bus.i_d_req = dr; bus.i_d_addr = da;
    bus.i_d_wren = dw; bus.i_d_wdata = wd; bus.i_d_bmask = bm; bus.i_d_lock = lk;
    #1;
    ed = dr && (m_locked || !ir || FIXED || !m_last_d);
    ei = ir && !m_locked && !ed;
    chk("i_gnt", bus.o_i_gnt, ei);
    chk("d_gnt", bus.o_d_gnt, ed);
    chk("mem_wren", bus.o_mem_wren, ed && dw);
    chk("mem_addr", bus.o_mem_addr, ed ? da : ia);
    chk("mem_bmask", bus.o_mem_bmask, ed ? bm : 4'h0);
    chk("i_rvalid", bus.o_i_rvalid, e_iv);
    chk("i_rdata", bus.o_i_rdata, e_ird);
    chk("d_rvalid", bus.o_d_rvalid, e_dv);
    chk("d_rdata", bus.o_d_rdata, e_drd);
    chk("cnt", cnt, m_cnt);
    obs_i = bus.o_i_gnt; obs_d = bus.o_d_gnt;
    wr = bus.o_mem_wren; wa = bus.o_mem_addr; wv = bus.o_mem_wdata; wb = bus.o_mem_bmask;
    e_iv = ei; e_dv = ed;
    if (ei) e_ird = ref_mem[ia[7:2]];
    if (ed) e_drd = ref_mem[da[7:2]];
    if (ed && dw) for (int b = 0; b < 4; b++) if (bm[b]) ref_mem[da[7:2]][b*8+:8] = wd[b*8+:8];
    if (!m_locked && (ei || ed)) m_last_d = ed;
    if (ed) m_locked = lk;
    if (((ir && !ei) || (dr && !ed)) && m_cnt < (1 << CW) - 1) m_cnt++;
    @(posedge clk); #1;
    if (wr) for (int b = 0; b < 4; b++) if (wb[b]) mem[wa[7:2]][b*8+:8] = wv[b*8+:8];
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    bus.i_i_req = 1'b1; bus.i_d_req = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_i_gnt", bus.o_i_gnt, 0);
    chk("rst_d_gnt", bus.o_d_gnt, 0);
    chk("rst_wren", bus.o_mem_wren, 0);
    chk("rst_i_rvalid", bus.o_i_rvalid, 0);
    chk("rst_d_rvalid", bus.o_d_rvalid, 0);
    chk("rst_i_rdata", bus.o_i_rdata, 0);
    chk("rst_d_rdata", bus.o_d_rdata, 0);
    chk("rst_cnt", cnt, 0);
    m_locked = 0; m_last_d = 1; e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0; m_cnt = 0;
    @(negedge clk);
    bus.i_i_req = 1'b0; bus.i_d_req = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] ord;
    int denied;
    bit ir, dr, dw, lk;
    logic [31:0] ia, da, wd;
    logic [3:0] bm;
    bus.i_i_req = 0; bus.i_i_addr = '0; bus.i_d_req = 0; bus.i_d_addr = '0;
    bus.i_d_wren = 0; bus.i_d_wdata = '0; bus.i_d_bmask = '0; bus.i_d_lock = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hAABBCCDD;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    do_reset();
    cyc(1, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("fetch_gnt", obs_i, 1);
    chk("fetch_rvalid", bus.o_i_rvalid, 1);
    chk("fetch_rdata", bus.o_i_rdata, 32'hDEADBEEF);
    cyc(0, 0, 1, 32'h20, 1, 32'h11223344, 4'b0011, 0);
    chk("wr_rvalid", bus.o_d_rvalid, 1);
    chk("wr_old_word", bus.o_d_rdata, 32'hAABBCCDD);
    cyc(0, 0, 1, 32'h20, 0, 0, 0, 0);
    chk("rd_merged", bus.o_d_rdata, 32'hAABB3344);
    chk("no_conflict", cnt, 0);
    do_reset();
    ord = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'h10, 1, 32'h24, 0, 0, 0, 0);
      ord = {ord[4:0], obs_d};
    end
    chk("rr_order", ord, FIXED ? 6'b111111 : 6'b010101);
    chk("rr_cnt", cnt, 6);
    cyc(0, 0, 1, 32'h30, 0, 0, 0, 1);
    denied = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h14, 0, 0, 0, 0, 0, 0);
      denied += int'(!obs_i);
    end
    cyc(1, 32'h14, 1, 32'h30, 1, 32'h5A5A5A5A, 4'hF, 0);
    denied += int'(!obs_i);
    chk("lock_denied", denied, 4);
    cyc(1, 32'h14, 0, 0, 0, 0, 0, 0);
    chk("unlock_i_gnt", obs_i, 1);
    cyc(0, 0, 1, 32'h30, 0, 0, 0, 1);
    do_reset();
    cyc(1, 32'h18, 1, 32'h1C, 0, 0, 0, 0);
    chk("post_rst_first", obs_i, !FIXED);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 32'h18, 1, 32'h1C, 0, 0, 0, 0);
    chk("cnt_sat", cnt, 15);
    ir = 0; dr = 0; dw = 0; lk = 0; ia = '0; da = '0; wd = '0; bm = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ir || obs_i) begin ir = $urandom_range(0, 3) != 0; ia = $urandom & 32'hFF; end
      if (!dr || obs_d) begin
        dr = $urandom_range(0, 3) != 0; da = $urandom & 32'hFF; dw = $urandom_range(0, 1) != 0;
        wd = $urandom; bm = 4'($urandom); lk = $urandom_range(0, 3) == 0;
      end
      cyc(ir, ia, dr, da, dw, wd, bm, lk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
